// File: rtl/seg7_countdown_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_countdown_ctrl
//
// Display sequencer feeding the seven-segment driver. A start request first
// shows the selected operation symbol for OP_HOLD_TICKS ticks. It then counts
// the latched seconds value down to 0, one digit per tick. It finishes with a
// one-cycle done pulse. A cancel request aborts silently.
//
// Parameters:
//   TICK_CYCLES   - clock cycles per displayed second (>= 2)
//   OP_HOLD_TICKS - ticks the operation symbol is held before counting (>= 1)
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   i_start      in   start request (ignored while a sequence is running)
//   i_cancel     in   abort request (wins over i_start)
//   i_op_code    in   [2:0] operation to show, latched at start
//   i_seconds    in   [3:0] countdown start value, latched at start
//   o_en         out  driver display enable
//   o_disp_mode  out  0 = operation symbol, 1 = digit
//   o_op_code    out  [2:0] latched operation code
//   o_digit_val  out  [3:0] current countdown value
//   o_busy       out  high while the symbol or the countdown is shown
//   o_done       out  one-cycle pulse on normal completion
//
// Configuration:
//   SEG7_CD_BLINK_EN - when defined, o_en blinks once per tick (off for the
//   second half of each tick) while the countdown shows 3 or less.
// ---------------------------------------------------------------------------
module seg7_countdown_ctrl #(
    parameter int TICK_CYCLES   = 100_000_000,
    parameter int OP_HOLD_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_cancel,
    input  logic [2:0] i_op_code,
    input  logic [3:0] i_seconds,
    output logic       o_en,
    output logic       o_disp_mode,
    output logic [2:0] o_op_code,
    output logic [3:0] o_digit_val,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [26:0] TICK_LAST = 27'(TICK_CYCLES - 1);
    localparam int          HOLD_W    = (OP_HOLD_TICKS > 1) ? $clog2(OP_HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OP_HOLD_TICKS - 1);
`ifdef SEG7_CD_BLINK_EN
    localparam logic [26:0] TICK_HALF = 27'(TICK_CYCLES / 2);
`endif

    // LAUNCH is a one-cycle internal step between accepting a start and
    // showing the symbol; the outputs still look idle during it, which gives
    // the one-cycle start-to-display latency.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_SHOW_OP = 2'd2,
        ST_COUNT   = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [26:0]       cyc_cnt, cyc_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [2:0]        op_q, op_q_n;
    logic [3:0]        sec_q, sec_q_n;

    logic       en_n, mode_n, busy_n, done_n;
    logic [2:0] op_n;
    logic [3:0] digit_n;
    logic       tick;

    assign tick = (cyc_cnt == TICK_LAST);

    // Next-state and next-output logic. Outputs are computed from the state
    // being entered so that the registered outputs line up with the state.
    always_comb begin
        // NOTE: every variable gets a default before the case statement so
        // that no path leaves one unassigned, which would infer a latch.
        state_n = state;
        cyc_n   = tick ? 27'd0 : cyc_cnt + 27'd1;
        hold_n  = hold_cnt;
        op_q_n  = op_q;
        sec_q_n = sec_q;
        mode_n  = o_disp_mode;
        op_n    = o_op_code;
        digit_n = o_digit_val;
        done_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                cyc_n  = 27'd0;
                mode_n = 1'b0;
                if (i_start && !i_cancel) begin
                    op_q_n  = i_op_code;
                    sec_q_n = i_seconds;
                    state_n = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                cyc_n  = 27'd0;
                hold_n = '0;
                if (i_cancel) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_SHOW_OP;
                    op_n    = op_q;
                    mode_n  = 1'b0;
                end
            end

            ST_SHOW_OP: begin
                if (i_cancel) begin
                    state_n = ST_IDLE;
                    cyc_n   = 27'd0;
                    mode_n  = 1'b0;
                end else if (tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = ST_COUNT;
                        digit_n = sec_q;
                        mode_n  = 1'b1;
                    end else begin
                        hold_n = hold_cnt + HOLD_W'(1);
                    end
                end
            end

            ST_COUNT: begin
                if (i_cancel) begin
                    state_n = ST_IDLE;
                    cyc_n   = 27'd0;
                    mode_n  = 1'b0;
                end else if (tick) begin
                    if (o_digit_val == 4'd0) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                        mode_n  = 1'b0;
                    end else begin
                        digit_n = o_digit_val - 4'd1;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
                cyc_n   = 27'd0;
                mode_n  = 1'b0;
            end
        endcase

        busy_n = (state_n == ST_SHOW_OP) || (state_n == ST_COUNT);
        en_n   = busy_n;
`ifdef SEG7_CD_BLINK_EN
        // Final-seconds warning: dark for the second half of each tick.
        if ((state_n == ST_COUNT) && (digit_n <= 4'd3) && (cyc_n >= TICK_HALF)) begin
            en_n = 1'b0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cyc_cnt     <= 27'd0;
            hold_cnt    <= '0;
            op_q        <= 3'd0;
            sec_q       <= 4'd0;
            o_en        <= 1'b0;
            o_disp_mode <= 1'b0;
            o_op_code   <= 3'd0;
            o_digit_val <= 4'd0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state       <= state_n;
            cyc_cnt     <= cyc_n;
            hold_cnt    <= hold_n;
            op_q        <= op_q_n;
            sec_q       <= sec_q_n;
            o_en        <= en_n;
            o_disp_mode <= mode_n;
            o_op_code   <= op_n;
            o_digit_val <= digit_n;
            o_busy      <= busy_n;
            o_done      <= done_n;
        end
    end

endmodule

// File: tb/tb_seg7_countdown_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_countdown_ctrl
//
// Directed bench for seg7_countdown_ctrl with TICK_CYCLES=4, OP_HOLD_TICKS=2.
// Inputs change 1 ns after a rising edge; outputs are compared 1 ns after the
// rising edge. Cycle k of a run means "just after edge E+k", where E is the
// edge that samples i_start. Expected outputs for cycle k:
//   k = 1..8           symbol: en=1 mode=0 busy=1, digit holds previous value
//   k = 9..T           digit N - (k-9)/4, mode=1 busy=1   (T = 8 + 4*(N+1))
//   k = T+1            done=1, en=0 busy=0 mode=0
//   k = T+2            idle, done=0
// ---------------------------------------------------------------------------
module tb_seg7_countdown_ctrl;

    localparam int TC   = 4;
    localparam int HOLD = 2;

    typedef struct packed {
        logic       en;
        logic       mode;
        logic [2:0] op;
        logic [3:0] digit;
        logic       busy;
        logic       done;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic       i_cancel;
    logic [2:0] i_op_code;
    logic [3:0] i_seconds;
    logic       o_en;
    logic       o_disp_mode;
    logic [2:0] o_op_code;
    logic [3:0] o_digit_val;
    logic       o_busy;
    logic       o_done;

    int n_checks = 0;
    int n_pass   = 0;

    out_t obs;
    assign obs = {o_en, o_disp_mode, o_op_code, o_digit_val, o_busy, o_done};

    seg7_countdown_ctrl #(
        .TICK_CYCLES   (TC),
        .OP_HOLD_TICKS (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_cancel    (i_cancel),
        .i_op_code   (i_op_code),
        .i_seconds   (i_seconds),
        .o_en        (o_en),
        .o_disp_mode (o_disp_mode),
        .o_op_code   (o_op_code),
        .o_digit_val (o_digit_val),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Expected outputs at cycle k of a run started with (op, secs).
    function automatic out_t exp_at(input logic [2:0] op, input int secs,
                                    input logic [3:0] prev_digit, input int k);
        out_t e;
        int   show_len;
        int   t_busy;
        int   j;
        int   d;
        e        = '0;
        show_len = HOLD * TC;
        t_busy   = show_len + TC * (secs + 1);
        e.op     = op;
        if (k <= show_len) begin
            e.en    = 1'b1;
            e.busy  = 1'b1;
            e.digit = prev_digit;
        end else if (k <= t_busy) begin
            j       = k - show_len - 1;
            d       = secs - j / TC;
            e.en    = 1'b1;
            e.mode  = 1'b1;
            e.busy  = 1'b1;
            e.digit = 4'(d);
`ifdef SEG7_CD_BLINK_EN
            if (d <= 3 && (j % TC) >= TC / 2) e.en = 1'b0;
`endif
        end else if (k == t_busy + 1) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic out_t idle_out(input logic [2:0] op, input logic [3:0] digit);
        out_t e;
        e       = '0;
        e.op    = op;
        e.digit = digit;
        return e;
    endfunction

    // Called 1 ns after a rising edge; returns 1 ns after edge E.
    task automatic issue_start(input logic [2:0] op, input logic [3:0] secs);
        i_start   = 1'b1;
        i_op_code = op;
        i_seconds = secs;
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        i_op_code = 3'd0;
        i_seconds = 4'd0;
    endtask

    task automatic test_reset();
        out_t e;
        rst_n    = 1'b0;
        i_start  = 1'b0;
        i_cancel = 1'b0;
        i_op_code = 3'd0;
        i_seconds = 4'd0;
        #2;
        e = '0;
        n_checks++;
        if (obs !== e) $display("FAIL reset_async got %b required %b", obs, e);
        else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (obs !== e) $display("FAIL reset_idle k=%0d got %b required %b", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_normal();
        int   t_busy;
        out_t e;
        t_busy = HOLD * TC + TC * 4;
        issue_start(3'd1, 4'd3);
        for (int k = 1; k <= t_busy + 2; k++) begin
            @(posedge clk);
            #1;
            e = exp_at(3'd1, 3, 4'd0, k);
            n_checks++;
            if (obs !== e) $display("FAIL normal k=%0d got %b required %b", k, obs, e);
            else n_pass++;
        end
    endtask

    // Also exercises an op code above 3 passing through unchanged.
    task automatic test_seconds_zero();
        out_t e;
        issue_start(3'd5, 4'd0);
        for (int k = 1; k <= HOLD * TC + TC + 2; k++) begin
            @(posedge clk);
            #1;
            e = exp_at(3'd5, 0, 4'd0, k);
            n_checks++;
            if (obs !== e) $display("FAIL sec_zero k=%0d got %b required %b", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_cancel();
        out_t e;
        issue_start(3'd3, 4'd5);
        // Digit 2 of a 5-second run occupies k = 21..24.
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1;
            e = exp_at(3'd3, 5, 4'd0, k);
            n_checks++;
            if (obs !== e) $display("FAIL cancel_pre k=%0d got %b required %b", k, obs, e);
            else n_pass++;
        end
        i_cancel = 1'b1;
        @(posedge clk);
        #1;
        i_cancel = 1'b0;
        e = idle_out(3'd3, 4'd2);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (obs !== e) $display("FAIL cancel_idle k=%0d got %b required %b", k, obs, e);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        // A later run shows the held digit 2 during the symbol phase.
        issue_start(3'd2, 4'd1);
        for (int k = 1; k <= HOLD * TC + TC * 2 + 2; k++) begin
            @(posedge clk);
            #1;
            e = exp_at(3'd2, 1, 4'd2, k);
            n_checks++;
            if (obs !== e) $display("FAIL cancel_rerun k=%0d got %b required %b", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_start_while_busy();
        out_t e;
        issue_start(3'd6, 4'd2);
        for (int k = 1; k <= HOLD * TC + TC * 3 + 2; k++) begin
            @(posedge clk);
            #1;
            e = exp_at(3'd6, 2, 4'd0, k);
            n_checks++;
            if (obs !== e) $display("FAIL busy_start k=%0d got %b required %b", k, obs, e);
            else n_pass++;
            // Start requests during the symbol and during the count.
            if ((k >= 1 && k <= 2) || (k >= 9 && k <= 11)) begin
                i_start   = 1'b1;
                i_op_code = 3'd7;
                i_seconds = 4'd15;
            end else begin
                i_start   = 1'b0;
                i_op_code = 3'd0;
                i_seconds = 4'd0;
            end
        end
    endtask

    task automatic test_start_cancel_idle();
        out_t e;
        i_start   = 1'b1;
        i_cancel  = 1'b1;
        i_op_code = 3'd7;
        i_seconds = 4'd9;
        @(posedge clk);
        #1;
        i_start  = 1'b0;
        i_cancel = 1'b0;
        e = idle_out(3'd6, 4'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (obs !== e) $display("FAIL start_cancel_idle k=%0d got %b required %b", k, obs, e);
            else n_pass++;
        end
    endtask

    // i_start held from the last busy cycle: ignored there, accepted in the
    // o_done cycle.
    task automatic test_back_to_back();
        int   t_busy;
        out_t e;
        t_busy = HOLD * TC + TC * 2;
        issue_start(3'd4, 4'd1);
        for (int k = 1; k <= t_busy; k++) begin
            @(posedge clk);
            #1;
            e = exp_at(3'd4, 1, 4'd0, k);
            n_checks++;
            if (obs !== e) $display("FAIL b2b_first k=%0d got %b required %b", k, obs, e);
            else n_pass++;
        end
        i_start   = 1'b1;
        i_op_code = 3'd6;
        i_seconds = 4'd2;
        @(posedge clk);
        #1;
        e = exp_at(3'd4, 1, 4'd0, t_busy + 1);
        n_checks++;
        if (obs !== e) $display("FAIL b2b_done got %b required %b", obs, e);
        else n_pass++;
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        i_op_code = 3'd0;
        i_seconds = 4'd0;
        e = idle_out(3'd4, 4'd0);
        n_checks++;
        if (obs !== e) $display("FAIL b2b_gap got %b required %b", obs, e);
        else n_pass++;
        for (int k = 1; k <= HOLD * TC + TC * 3 + 2; k++) begin
            @(posedge clk);
            #1;
            e = exp_at(3'd6, 2, 4'd0, k);
            n_checks++;
            if (obs !== e) $display("FAIL b2b_second k=%0d got %b required %b", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_count();
        out_t e;
        issue_start(3'd2, 4'd4);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            e = exp_at(3'd2, 4, 4'd0, k);
            n_checks++;
            if (obs !== e) $display("FAIL rst_pre k=%0d got %b required %b", k, obs, e);
            else n_pass++;
        end
        #3;
        rst_n = 1'b0;
        #1;
        e = '0;
        n_checks++;
        if (obs !== e) $display("FAIL rst_async_mid got %b required %b", obs, e);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (obs !== e) $display("FAIL rst_post_idle k=%0d got %b required %b", k, obs, e);
            else n_pass++;
        end
        issue_start(3'd1, 4'd0);
        for (int k = 1; k <= HOLD * TC + TC + 2; k++) begin
            @(posedge clk);
            #1;
            e = exp_at(3'd1, 0, 4'd0, k);
            n_checks++;
            if (obs !== e) $display("FAIL rst_rerun k=%0d got %b required %b", k, obs, e);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_seconds_zero();
        test_cancel();
        test_start_while_busy();
        test_start_cancel_idle();
        test_back_to_back();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
